pong_match_ctrl: RTL

Match-level controller for the Pong core, clocked by the per-frame game tick. It consumes goal events from the ball-physics stage and the player's start/pause buttons. It produces the ball run/recentre controls, the serve direction, the packed 8-bit score and the game-over indication that the physics and VGA render stages read. Its state machine covers idle, serve delay, play, pause, point hold and game over.

---
 rtl/pong_match_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Match-level controller for the Pong core: sequences idle, serve delay, play,
// pause, point hold and game over, and keeps the packed score for physics/render.
module pong_match_ctrl #(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 4,
   parameter int POINT_HOLD  = 8
) (
   input  logic       clk_div,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic       player_goal,
   input  logic       opp_goal,
   output logic       ball_run,
   output logic       ball_reset,
   output logic       serve_dir_x,
   output logic [7:0] score,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_POINT = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY - 1);
   localparam logic [7:0] POINT_LOAD = 8'(POINT_HOLD - 1);
   localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] player_q, player_d;
   logic [3:0] opp_q, opp_d;
   logic       serve_dir_q, serve_dir_d;
   logic       winner_q, winner_d;
   logic       start_prev_q, pause_prev_q;

   logic       start_edge, pause_edge;
   logic [3:0] player_inc, opp_inc;

   assign start_edge = start_btn & ~start_prev_q;
   assign pause_edge = pause_btn & ~pause_prev_q;
   assign player_inc = player_q + 4'd1;
   assign opp_inc    = opp_q + 4'd1;

   always_ff @(posedge clk_div) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         player_q     <= 4'd0;
         opp_q        <= 4'd0;
         serve_dir_q  <= 1'b1;
         winner_q     <= 1'b0;
         start_prev_q <= 1'b0;
         pause_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         player_q     <= player_d;
         opp_q        <= opp_d;
         serve_dir_q  <= serve_dir_d;
         winner_q     <= winner_d;
         start_prev_q <= start_btn;
         pause_prev_q <= pause_btn;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      player_d    = player_q;
      opp_d       = opp_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end
         end

         ST_SERVE: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_PLAY;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         ST_PLAY: begin
            // A goal on the same tick as a pause edge takes precedence.
            if (player_goal && opp_goal) begin
               state_d = ST_POINT;
               cnt_d   = POINT_LOAD;
            end else if (player_goal) begin
               player_d    = player_inc;
               serve_dir_d = 1'b0;
               if (player_inc == WIN_VAL) begin
                  state_d  = ST_OVER;
                  winner_d = 1'b1;
               end else begin
                  state_d = ST_POINT;
                  cnt_d   = POINT_LOAD;
               end
            end else if (opp_goal) begin
               opp_d       = opp_inc;
               serve_dir_d = 1'b1;
               if (opp_inc == WIN_VAL) begin
                  state_d  = ST_OVER;
                  winner_d = 1'b0;
               end else begin
                  state_d = ST_POINT;
                  cnt_d   = POINT_LOAD;
               end
            end else if (pause_edge) begin
               state_d = ST_PAUSE;
            end
         end

         ST_PAUSE: begin
            if (pause_edge) begin
               state_d = ST_PLAY;
            end
         end

         ST_POINT: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         ST_OVER: begin
            if (start_edge) begin
               state_d     = ST_SERVE;
               cnt_d       = SERVE_LOAD;
               player_d    = 4'd0;
               opp_d       = 4'd0;
               winner_d    = 1'b0;
               serve_dir_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded purely from the state register.
   always_comb begin
      ball_run   = 1'b0;
      ball_reset = 1'b1;
      game_over  = 1'b0;
      case (state_q)
         ST_PLAY: begin
            ball_run   = 1'b1;
            ball_reset = 1'b0;
         end
         ST_PAUSE: begin
            ball_reset = 1'b0;
         end
         ST_OVER: begin
            game_over = 1'b1;
         end
         default: begin
            ball_run   = 1'b0;
         end
      endcase
   end

   assign score       = {opp_q, player_q};
   assign serve_dir_x = serve_dir_q;
   assign winner      = winner_q;
   assign state_dbg   = state_q;

endmodule
